// File: rtl/apb_reg_bank.sv
// APB3 slave register bank: NUM_CTRL RW control registers, a read-only status word,
// and a W1C interrupt-pending register gated by an enable register. Wait states are programmable.
module apb_reg_bank #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_CTRL    = 4,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CTRL_RST    = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESETN,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_q,
  output logic [NUM_CTRL-1:0]          ctrl_wr_pulse,
  input  logic [DATA_W-1:0]            status_in,
  input  logic [DATA_W-1:0]            irq_evt,
  output logic                         irq
);

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_CTRL);
  localparam logic [IW-1:0] PEND_IDX   = IW'(NUM_CTRL + 1);
  localparam logic [IW-1:0] EN_IDX     = IW'(NUM_CTRL + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [IW-1:0]       addr_reg;
  logic                write_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   prdata_reg;
  logic                pslverr_reg;
  logic [DATA_W-1:0]   pend_reg, en_reg;
  logic                irq_reg;
  logic                latch, complete, wr_en, enter_ready;
  logic [IW-1:0]       rd_idx;
  logic                rd_write, rd_err;
  logic [DATA_W-1:0]   rd_val, pend_clr;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^PADDR[1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch      = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          latch      = 1'b1;
          cnt_next   = 4'(WAIT_STATES);
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_READY;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) state_next = S_READY;
        end
      end
      S_READY: begin
        if (!PSEL) begin
          state_next = S_IDLE;
        end else if (PENABLE) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states READY is entered straight from the setup edge, so decode the live bus then.
  always_comb begin
    rd_idx   = latch ? PADDR[ADDR_W-1:2] : addr_reg;
    rd_write = latch ? PWRITE : write_reg;
    rd_err   = rd_idx > EN_IDX;
    rd_val   = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (rd_idx == IW'(i)) rd_val = ctrl_q[i*DATA_W +: DATA_W];
    end
    if (rd_idx == STATUS_IDX) rd_val = status_in;
    if (rd_idx == PEND_IDX)   rd_val = pend_reg;
    if (rd_idx == EN_IDX)     rd_val = en_reg;
  end

  assign enter_ready = (state_next == S_READY) && (state_reg != S_READY);
  assign wr_en       = complete && write_reg;
  assign pend_clr    = (wr_en && addr_reg == PEND_IDX) ? wdata_reg : '0;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
      pend_reg    <= '0;
      en_reg      <= '0;
      irq_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (latch) begin
        addr_reg  <= PADDR[ADDR_W-1:2];
        write_reg <= PWRITE;
        wdata_reg <= PWDATA;
      end
      if (enter_ready) begin
        prdata_reg  <= rd_write ? '0 : rd_val;
        pslverr_reg <= rd_err;
      end else if (state_next != S_READY) begin
        prdata_reg  <= '0;
        pslverr_reg <= 1'b0;
      end
      // A new event outranks a simultaneous clear.
      pend_reg <= (pend_reg & ~pend_clr) | irq_evt;
      if (wr_en && addr_reg == EN_IDX) en_reg <= wdata_reg;
      irq_reg <= |(pend_reg & en_reg);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
      logic [DATA_W-1:0] q_reg;
      logic              pulse_reg;
      logic              hit;
      assign hit = wr_en && (addr_reg == IW'(gi));
      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
          q_reg     <= CTRL_RST;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          if (hit) q_reg <= wdata_reg;
        end
      end
      assign ctrl_q[gi*DATA_W +: DATA_W] = q_reg;
      assign ctrl_wr_pulse[gi]           = pulse_reg;
    end
  endgenerate

  assign PREADY  = (state_reg == S_READY);
  assign PRDATA  = prdata_reg;
  assign PSLVERR = pslverr_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: a zero-wait instance (dut0) and a three-wait instance (dut3)
// driven through separate buses, with a scoreboard of expected read/error/latency results.
module tb_apb_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   psel, penable, pwrite, pready, pslverr, irq;
  logic [7:0]   paddr   [2];
  logic [31:0]  pwdata  [2];
  logic [31:0]  prdata  [2];
  logic [31:0]  irq_evt [2];
  logic [127:0] ctrl_q  [2];
  logic [3:0]   wr_pulse[2];
  logic [31:0]  status_in;

  apb_reg_bank #(.DATA_W(32), .ADDR_W(8), .NUM_CTRL(4), .WAIT_STATES(0), .CTRL_RST(32'h0)) dut0 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .ctrl_q(ctrl_q[0]), .ctrl_wr_pulse(wr_pulse[0]),
    .status_in(status_in), .irq_evt(irq_evt[0]), .irq(irq[0]));

  apb_reg_bank #(.DATA_W(32), .ADDR_W(8), .NUM_CTRL(4), .WAIT_STATES(3), .CTRL_RST(32'h0)) dut3 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .ctrl_q(ctrl_q[1]), .ctrl_wr_pulse(wr_pulse[1]),
    .status_in(status_in), .irq_evt(irq_evt[1]), .irq(irq[1]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        is_rd;
  } exp_t;
  exp_t sb_q[$];

  // Reference model of register contents per instance.
  logic [31:0] ctrl_m [2][4];
  logic [31:0] pend_m [2];
  logic [31:0] en_m   [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) ctrl_m[d][i] = 32'h0;
      pend_m[d] = 32'h0;
      en_m[d]   = 32'h0;
    end
  endtask

  function automatic logic [127:0] ctrl_pack(input int d);
    return {ctrl_m[d][3], ctrl_m[d][2], ctrl_m[d][1], ctrl_m[d][0]};
  endfunction

  function automatic logic [31:0] model_rd(input int d, input int idx);
    if (idx < 4)  return ctrl_m[d][idx];
    if (idx == 4) return status_in;
    if (idx == 5) return pend_m[d];
    if (idx == 6) return en_m[d];
    return 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; evt is applied to irq_evt on the completing edge.
  task automatic apb(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] evt, input int exp_waits);
    exp_t        e;
    int          idx;
    int          waits;
    logic [31:0] rd;
    logic        er;
    idx     = int'(addr[7:2]);
    e.rdata = model_rd(d, idx);
    e.err   = (idx > 6);
    e.waits = exp_waits;
    e.is_rd = !wr;
    sb_q.push_back(e);
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    @(negedge clk);
    penable[d] = 1'b1;
    waits = 0;
    while (!pready[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    rd = prdata[d];
    er = pslverr[d];
    irq_evt[d] = evt;
    @(posedge clk);
    #1;
    psel[d] = 1'b0; penable[d] = 1'b0; irq_evt[d] = 32'h0;
    if (wr && idx < 4) ctrl_m[d][idx] = wd;
    if (wr && idx == 6) en_m[d] = wd;
    pend_m[d] = ((wr && idx == 5) ? (pend_m[d] & ~wd) : pend_m[d]) | evt;
    e = sb_q.pop_front();
    check_val("waits", 128'(waits), 128'(e.waits));
    if (e.is_rd) check_val("prdata", 128'(rd), 128'(e.rdata));
    check_val("pslverr", 128'(er), 128'(e.err));
    $display("xfer dut%0d %s addr=%02h wdata=%08h rdata=%08h slverr=%0b waits=%0d",
             d, wr ? "WR" : "RD", addr, wd, rd, er, waits);
  endtask

  task automatic pulse_evt(input int d, input logic [31:0] v);
    @(negedge clk);
    irq_evt[d] = v;
    step();
    irq_evt[d] = 32'h0;
    pend_m[d] |= v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    psel = '0; penable = '0; pwrite = '0; status_in = 32'h0;
    for (int d = 0; d < 2; d++) begin
      paddr[d] = 8'h0; pwdata[d] = 32'h0; irq_evt[d] = 32'h0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val("rst_pready",  128'(pready[d]),   128'(0));
      check_val("rst_pslverr", 128'(pslverr[d]),  128'(0));
      check_val("rst_prdata",  128'(prdata[d]),   128'(0));
      check_val("rst_ctrl_q",  ctrl_q[d],         ctrl_pack(d));
      check_val("rst_pulse",   128'(wr_pulse[d]), 128'(0));
      check_val("rst_irq",     128'(irq[d]),      128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents of every control register, zero wait states
    for (int i = 0; i < 4; i++) apb(0, 1'b0, 8'(i * 4), 32'h0, 32'h0, 0);

    // Control write, pulse, readback; PADDR[1:0] ignored
    apb(0, 1'b1, 8'h08, 32'hDEADBEEF, 32'h0, 0);
    check_val("ctrl_q_wr", ctrl_q[0], ctrl_pack(0));
    check_val("pulse_wr",  128'(wr_pulse[0]), 128'(4'b0100));
    step();
    check_val("pulse_gone", 128'(wr_pulse[0]), 128'(0));
    apb(0, 1'b0, 8'h08, 32'h0, 32'h0, 0);
    apb(0, 1'b0, 8'h0B, 32'h0, 32'h0, 0);
    apb(0, 1'b0, 8'h04, 32'h0, 32'h0, 0);

    // Three wait states: status read, ignored status write, control write
    status_in = 32'h12345678;
    apb(1, 1'b0, 8'h10, 32'h0, 32'h0, 3);
    apb(1, 1'b1, 8'h10, 32'hFFFF0000, 32'h0, 3);
    check_val("status_wr_q", ctrl_q[1], ctrl_pack(1));
    check_val("status_wr_pulse", 128'(wr_pulse[1]), 128'(0));
    apb(1, 1'b1, 8'h0C, 32'hCAFEF00D, 32'h0, 3);
    check_val("pulse_ws3", 128'(wr_pulse[1]), 128'(4'b1000));
    apb(1, 1'b0, 8'h0C, 32'h0, 32'h0, 3);

    // Interrupt pending / enable
    pulse_evt(0, 32'h5);
    step();
    check_val("irq_noen", 128'(irq[0]), 128'(0));
    apb(0, 1'b1, 8'h18, 32'h4, 32'h0, 0);
    check_val("irq_lag", 128'(irq[0]), 128'(0));
    step();
    check_val("irq_en", 128'(irq[0]), 128'(|(pend_m[0] & en_m[0])));
    apb(0, 1'b0, 8'h14, 32'h0, 32'h0, 0);
    apb(0, 1'b1, 8'h14, 32'h4, 32'h4, 0);
    apb(0, 1'b0, 8'h14, 32'h0, 32'h0, 0);
    check_val("irq_setwins", 128'(irq[0]), 128'(1));
    apb(0, 1'b1, 8'h14, 32'h4, 32'h0, 0);
    step();
    check_val("irq_clr", 128'(irq[0]), 128'(|(pend_m[0] & en_m[0])));
    apb(0, 1'b0, 8'h14, 32'h0, 32'h0, 0);
    apb(0, 1'b0, 8'h18, 32'h0, 32'h0, 0);

    // Unmapped indices
    apb(0, 1'b0, 8'h1C, 32'h0, 32'h0, 0);
    apb(0, 1'b1, 8'h1C, 32'hFFFFFFFF, 32'h0, 0);
    check_val("unmap_pulse", 128'(wr_pulse[0]), 128'(0));
    check_val("unmap_ctrl_q", ctrl_q[0], ctrl_pack(0));
    apb(0, 1'b0, 8'hFC, 32'h0, 32'h0, 0);

    // Reset asserted in WAIT of a control-0 write
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 32'hA5A5A5A5;
    @(negedge clk);
    penable[1] = 1'b1;
    check_val("wait_pready", 128'(pready[1]), 128'(0));
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("abort_pready", 128'(pready[1]), 128'(0));
    check_val("abort_ctrl_q", ctrl_q[1], ctrl_pack(1));
    check_val("abort_pulse",  128'(wr_pulse[1]), 128'(0));
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apb(1, 1'b0, 8'h00, 32'h0, 32'h0, 3);
    check_val("post_abort_q", ctrl_q[1], ctrl_pack(1));
    apb(0, 1'b0, 8'h08, 32'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
